cla_seq_adder: RTL
==================

// Module: cla_seq_adder
// PURPOSE
//   Multi-precision adder sequencer. Reuses one CLA_4 instance to add WIDTH-bit
//   operands one nibble per cycle, LSB nibble first, holding the ripple carry
//   in a register between nibbles.
//   Sits between a requester and the result consumer, with valid/ready on both sides.
//   Trades latency for area compared with a full-width CLA.
// PARAMETERS
//   WIDTH    16  operand/result width; multiple of 4, >= 8
//   NIBBLES  WIDTH/4 (localparam)  add cycles per operation
// PORTS
//   clk        in   1      single clock; all state on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A, sampled on accept
//   b          in   WIDTH  operand B, sampled on accept
//   cin        in   1      carry-in, sampled on accept
//   out_valid  out  1      result valid (high only in DONE)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  a+b+cin mod 2^WIDTH
//   cout       out  1      unsigned carry-out
//   ovf        out  1      signed overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, cnt=0, carry=0.
//     sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 (once IDLE).
//   FSM IDLE -> RUN -> DONE -> IDLE. in_ready/out_valid/busy decode state only.
//   IDLE: if in_valid, the edge latches a->a_sh, b->b_sh, cin->carry, cnt=0.
//     The edge also latches a[WIDTH-1] and b[WIDTH-1], then goes to RUN.
//   RUN, each edge:
//     CLA_4 inputs are a_sh[3:0], b_sh[3:0] and carry.
//     carry <= CLA_4 cout. a_sh and b_sh shift right by 4.
//     res <= {CLA_4 sum, res[WIDTH-1:4]}.
//     cnt++. If cnt==NIBBLES-1, go to DONE and load sum/cout/ovf from final values.
//   DONE: out_valid=1. sum/cout/ovf held stable until out_ready=1.
//     On out_valid && out_ready, go to IDLE. Outputs keep their last value.
//   Latency: out_valid rises NIBBLES edges after the accept edge.
//     Min spacing between accepts = NIBBLES+2 cycles.
//   in_valid while busy: ignored, nothing latched; the requester must hold it.
//   out_ready while not DONE: ignored.
//   Operand change after accept: no effect on the operation in flight.
//   Reset mid-RUN or in DONE: operation aborted, result discarded, reset values apply.
//   Arithmetic: {cout,sum} == a+b+cin computed at WIDTH+1 bits; no saturation.
// TESTING (WIDTH=16 unless noted)
//   1. Reset: assert rst_n=0 mid-clock.
//      -> outputs reset immediately, no clock edge needed.
//      -> in_ready=1, out_valid=0, sum=0x0000.
//   2. a=0xFFFF, b=0x0001, cin=0.
//      -> sum=0x0000, cout=1, ovf=0.
//      -> out_valid exactly 4 edges after the accept edge.
//   3. a=0x7FFF, b=0x0001, cin=0.
//      -> sum=0x8000, cout=0, ovf=1.
//      a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
//   4. out_ready=0 for 10 cycles in DONE, with in_valid pulsed high during that time.
//      -> sum/cout stable, in_ready=0, no new op accepted.
//   5. rst_n low after 2 RUN edges of a=0x1234, b=0x4321.
//      -> clean reset.
//      Next op a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
//   6. 1000 random a/b/cin with random out_ready stalls, at WIDTH=16 and WIDTH=8.
//      -> {cout,sum} == a+b+cin for every vector.
//      -> ovf matches the sign rule for every vector.

Source files
------------

// File: rtl/cla_seq_adder.sv
// Multi-precision adder sequencer: a single 4-bit carry-lookahead slice is reused
// once per nibble, LSB first, with the ripple carry held in a register between nibbles.
module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = $clog2(NIBBLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 4-bit carry-lookahead slice; returns {carry_out, sum_nibble}
    function automatic logic [4:0] cla_4(input logic [3:0] x, input logic [3:0] y,
                                         input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [4:0]       w_cla;
    logic [WIDTH-1:0] w_res_next;

    assign w_cla      = cla_4(r_a_sh[3:0], r_b_sh[3:0], r_carry);
    assign w_res_next = {w_cla[3:0], r_res[WIDTH-1:4]};

    // Sequencer FSM with registered handshake flags and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res       <= '0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh     <= a;
                        r_b_sh     <= b;
                        r_carry    <= cin;
                        r_cnt      <= '0;
                        r_res      <= '0;
                        r_a_msb    <= a[WIDTH-1];
                        r_b_msb    <= b[WIDTH-1];
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_carry <= w_cla[4];
                    r_a_sh  <= {4'b0000, r_a_sh[WIDTH-1:4]};
                    r_b_sh  <= {4'b0000, r_b_sh[WIDTH-1:4]};
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        // the last nibble's sum bit 3 is the result sign bit
                        r_sum       <= w_res_next;
                        r_cout      <= w_cla[4];
                        r_ovf       <= (r_a_msb == r_b_msb) && (w_cla[3] != r_a_msb);
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
